// File: rtl/sram_access_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sram_arb_pkg
//   Shared types for the SRAM access arbiter: access-sequencer state encoding,
//   requester identifiers and the default wait-state count.
// ---------------------------------------------------------------------------
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        RELEASE
    } arb_state_t;

    typedef enum logic {
        REQ_CPU,
        REQ_DBG
    } req_id_t;

    localparam int DEFAULT_WAIT = 2;

endpackage

// File: rtl/sram_access_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_access_arbiter_if
//   Requester-side handshake bundle for one SRAM client.
//   req   : access request, held until ack
//   we    : 1 = write, 0 = read
//   addr  : word address
//   wdata : write data
//   rdata : read data, valid in the ack cycle and held afterwards
//   ack   : one-cycle completion pulse
//   master modport = requester, slave modport = arbiter.
// ---------------------------------------------------------------------------
interface sram_access_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/sram_access_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//   Combinational 2-way round-robin pick.
//   i_req[0]     : requester REQ_CPU
//   i_req[1]     : requester REQ_DBG
//   i_last_grant : requester served most recently
//   o_gnt_valid  : at least one request present
//   o_gnt_id     : chosen requester (lone requester wins; on a tie the one
//                  not served last wins)
// ---------------------------------------------------------------------------
module rr_arb2
    import sram_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  req_id_t    i_last_grant,
    output logic       o_gnt_valid,
    output req_id_t    o_gnt_id
);

    always_comb begin
        o_gnt_valid = |i_req;
        o_gnt_id    = REQ_CPU;
        case (i_req)
            2'b01:   o_gnt_id = REQ_CPU;
            2'b10:   o_gnt_id = REQ_DBG;
            2'b11:   o_gnt_id = (i_last_grant == REQ_CPU) ? REQ_DBG : REQ_CPU;
            default: o_gnt_id = REQ_CPU;
        endcase
    end

endmodule

// File: rtl/sram_access_arbiter.sv
// ---------------------------------------------------------------------------
// sram_access_arbiter
//   Shares one asynchronous SRAM between the CPU memory path and the debug /
//   program-loader port. Each access runs SETUP -> STROBE (WAIT_STATES
//   cycles) -> RELEASE, and the granted requester gets a one-cycle ack in
//   RELEASE. All outputs are registered.
//
//   Clk, Reset   : clock, synchronous active-high reset
//   cpu          : requester 0 handshake (slave side)
//   dbg          : requester 1 handshake (slave side)
//   sram_addr    : SRAM word address
//   sram_dq_out  : write data toward the pad driver
//   sram_dq_oe   : 1 = pads driven with sram_dq_out
//   sram_dq_in   : data sampled from the pads
//   Mem_CE/UB/LB : chip / byte enables, active-low
//   Mem_OE/WE    : output / write enable, active-low
// ---------------------------------------------------------------------------
module sram_access_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16,
    parameter int WAIT_STATES = DEFAULT_WAIT
) (
    input  logic              Clk,
    input  logic              Reset,
    sram_access_arbiter_if.slave cpu,
    sram_access_arbiter_if.slave dbg,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_in,
    output logic              Mem_CE,
    output logic              Mem_UB,
    output logic              Mem_LB,
    output logic              Mem_OE,
    output logic              Mem_WE
);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    req_id_t           r_grant;
    req_id_t           r_last_grant;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [3:0]        r_wait;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_dbg_rdata;
    logic              r_cpu_ack;
    logic              r_dbg_ack;
    logic              r_ce_n;
    logic              r_oe_n;
    logic              r_we_n;
    logic              r_dq_oe;

    logic              w_gnt_valid;
    req_id_t           w_gnt_id;
    req_id_t           w_grant_sel;
    logic              w_we_sel;
    logic              w_ce_n_next;
    logic              w_oe_n_next;
    logic              w_we_n_next;
    logic              w_dq_oe_next;
    logic              w_cpu_ack_next;
    logic              w_dbg_ack_next;

    rr_arb2 u_rr_arb2 (
        .i_req        ({dbg.req, cpu.req}),
        .i_last_grant (r_last_grant),
        .o_gnt_valid  (w_gnt_valid),
        .o_gnt_id     (w_gnt_id)
    );

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_gnt_valid) w_state_next = SETUP;
            SETUP:   w_state_next = STROBE;
            STROBE:  if (r_wait == 4'd0) w_state_next = RELEASE;
            RELEASE: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Outputs are registered, so they are decoded from the state being
    // entered. On the IDLE->SETUP edge the latched grant/we are not yet
    // valid, so the live arbiter pick is used instead.
    always_comb begin
        w_grant_sel = r_grant;
        w_we_sel    = r_we;
        if (r_state == IDLE) begin
            w_grant_sel = w_gnt_id;
            w_we_sel    = (w_gnt_id == REQ_DBG) ? dbg.we : cpu.we;
        end
        w_ce_n_next    = (w_state_next == IDLE);
        w_oe_n_next    = !((w_state_next == STROBE) && !w_we_sel);
        w_we_n_next    = !((w_state_next == STROBE) && w_we_sel);
        w_dq_oe_next   = (w_state_next != IDLE) && w_we_sel;
        w_cpu_ack_next = (w_state_next == RELEASE) && (w_grant_sel == REQ_CPU);
        w_dbg_ack_next = (w_state_next == RELEASE) && (w_grant_sel == REQ_DBG);
    end

    // State, datapath and output registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= IDLE;
            r_grant      <= REQ_CPU;
            r_last_grant <= REQ_DBG;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wait       <= '0;
            r_cpu_rdata  <= '0;
            r_dbg_rdata  <= '0;
            r_cpu_ack    <= 1'b0;
            r_dbg_ack    <= 1'b0;
            r_ce_n       <= 1'b1;
            r_oe_n       <= 1'b1;
            r_we_n       <= 1'b1;
            r_dq_oe      <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cpu_ack <= w_cpu_ack_next;
            r_dbg_ack <= w_dbg_ack_next;
            r_ce_n    <= w_ce_n_next;
            r_oe_n    <= w_oe_n_next;
            r_we_n    <= w_we_n_next;
            r_dq_oe   <= w_dq_oe_next;
            case (r_state)
                IDLE: begin
                    if (w_gnt_valid) begin
                        r_grant <= w_gnt_id;
                        if (w_gnt_id == REQ_DBG) begin
                            r_we    <= dbg.we;
                            r_addr  <= dbg.addr;
                            r_wdata <= dbg.wdata;
                        end else begin
                            r_we    <= cpu.we;
                            r_addr  <= cpu.addr;
                            r_wdata <= cpu.wdata;
                        end
                    end
                end
                SETUP: r_wait <= 4'(WAIT_STATES - 1);
                STROBE: begin
                    if (r_wait == 4'd0) begin
                        if (!r_we) begin
                            if (r_grant == REQ_DBG) r_dbg_rdata <= sram_dq_in;
                            else                    r_cpu_rdata <= sram_dq_in;
                        end
                    end else begin
                        r_wait <= r_wait - 4'd1;
                    end
                end
                RELEASE: r_last_grant <= r_grant;
                default: ;
            endcase
        end
    end

    assign sram_addr   = r_addr;
    assign sram_dq_out = r_wdata;
    assign sram_dq_oe  = r_dq_oe;
    assign Mem_CE      = r_ce_n;
    assign Mem_UB      = r_ce_n;
    assign Mem_LB      = r_ce_n;
    assign Mem_OE      = r_oe_n;
    assign Mem_WE      = r_we_n;
    assign cpu.rdata   = r_cpu_rdata;
    assign cpu.ack     = r_cpu_ack;
    assign dbg.rdata   = r_dbg_rdata;
    assign dbg.ack     = r_dbg_ack;

endmodule
